// File: rtl/can_frame_tx_if.sv
// can_frame_tx_if
//   User-side frame handshake and status for the CAN frame transmitter.
//   master : frame source (drives tx_valid and the frame fields)
//   slave  : transmitter  (drives tx_ready and the outcome strobes)
// Signals:
//   tx_valid / tx_ready : frame offer, accepted when both are high on a clk edge
//   tx_id[28:0]         : identifier, standard frames use tx_id[10:0]
//   tx_ide / tx_rtr     : extended-frame flag / remote-frame flag
//   tx_len[3:0]         : DLC, sent verbatim
//   tx_data[63:0]       : payload, byte0 = tx_data[63:56], MSB first
//   tx_done / tx_acked  : completion pulse and its ACK-slot result
//   tx_arb_lost / tx_err: drop pulses
interface can_frame_tx_if;
  logic        tx_valid;
  logic        tx_ready;
  logic [28:0] tx_id;
  logic        tx_ide;
  logic        tx_rtr;
  logic [3:0]  tx_len;
  logic [63:0] tx_data;
  logic        tx_done;
  logic        tx_acked;
  logic        tx_arb_lost;
  logic        tx_err;

  modport master (
    output tx_valid, tx_id, tx_ide, tx_rtr, tx_len, tx_data,
    input  tx_ready, tx_done, tx_acked, tx_arb_lost, tx_err
  );

  modport slave (
    input  tx_valid, tx_id, tx_ide, tx_rtr, tx_len, tx_data,
    output tx_ready, tx_done, tx_acked, tx_arb_lost, tx_err
  );
endinterface

// File: rtl/can_frame_tx.sv
// can_frame_tx
//   CAN 2.0A/2.0B frame transmitter on the bit layer's strobe interface.
//   Waits for bus idle, sends SOF..CRC with bit stuffing and CRC-15, then
//   the CRC delimiter, ACK slot and ACK delimiter, watching the bus for
//   arbitration loss and bit/form errors.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   bit_req   : one-cycle strobe per bit time at the sample point
//   bit_rx    : bus value of the bit currently on bit_tx (valid with bit_req)
//   bit_tx    : registered bit to drive, 1 = recessive
//   tx        : frame handshake and outcome (can_frame_tx_if.slave)
//
// state      | meaning
// -----------+------------------------------------------------------------
// WAIT_IDLE  | bus busy or just released; count recessive bits, no frame held
// IDLE       | bus idle, tx_ready high, waiting for a frame
// PEND       | frame held, waiting for a recessive sample after idle to send SOF
// SHIFT      | sending SOF..last CRC bit with stuffing
// CRC_DEL    | CRC delimiter on the bus
// ACK_SLOT   | ACK slot on the bus, sampling the receivers' ACK
// ACK_DEL    | ACK delimiter on the bus, reporting the outcome
module can_frame_tx #(
  parameter int unsigned IDLE_BITS = 11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          bit_req,
  input  logic          bit_rx,
  output logic          bit_tx,
  can_frame_tx_if.slave tx
);

  localparam logic [2:0] S_WAIT_IDLE = 3'd0;
  localparam logic [2:0] S_IDLE      = 3'd1;
  localparam logic [2:0] S_PEND      = 3'd2;
  localparam logic [2:0] S_SHIFT     = 3'd3;
  localparam logic [2:0] S_CRC_DEL   = 3'd4;
  localparam logic [2:0] S_ACK_SLOT  = 3'd5;
  localparam logic [2:0] S_ACK_DEL   = 3'd6;

  localparam logic [14:0] CRC_POLY = 15'h4599;
  localparam logic [7:0]  IDLE_CNT = 8'(IDLE_BITS);

  logic [2:0]   state;
  logic [7:0]   idle_cnt;
  logic [102:0] sreg;       // unstuffed SOF..data, next bit at [102]
  logic [6:0]   pre_total;  // unstuffed SOF..data length of the held frame
  logic [6:0]   pre_left;   // unstuffed bits still to load after the current one
  logic         ide_q;
  logic [14:0]  crc;
  logic [3:0]   crc_left;
  logic         last_crc;   // bit on bit_tx is the final CRC bit
  logic         cur_stuff;  // bit on bit_tx is a stuff bit
  logic [6:0]   bit_idx;    // unstuffed index of the bit on bit_tx (SOF = 0)
  logic [2:0]   run_cnt;
  logic         run_val;
  logic         ack_q;

  function automatic logic [14:0] crc_step(input logic [14:0] c, input logic b);
    crc_step = {c[13:0], 1'b0} ^ (((b ^ c[14]) != 1'b0) ? CRC_POLY : 15'd0);
  endfunction

  // Frame image built straight from the offered fields. Data always follows
  // the header; frame_bits decides how much of it is actually sent.
  logic [3:0]   data_bytes;
  logic [6:0]   frame_bits;
  logic [102:0] frame_vec;

  always_comb begin
    data_bytes = (tx.tx_len > 4'd8) ? 4'd8 : tx.tx_len;
    if (tx.tx_ide) begin
      frame_vec  = {1'b0, tx.tx_id[28:18], 1'b1, 1'b1, tx.tx_id[17:0],
                    tx.tx_rtr, 2'b00, tx.tx_len, tx.tx_data};
      frame_bits = 7'd39;
    end else begin
      frame_vec  = {1'b0, tx.tx_id[10:0], tx.tx_rtr, 2'b00, tx.tx_len,
                    tx.tx_data, 20'd0};
      frame_bits = 7'd19;
    end
    if (!tx.tx_rtr) frame_bits = frame_bits + {data_bytes, 3'b000};
  end

  // Next bit to load while in SHIFT. A stuff bit takes priority except
  // after the final CRC bit, where the delimiter follows directly.
  logic nxt_bit;
  logic nxt_stuff;
  logic nxt_from_pre;
  logic nxt_from_crc;
  logic shift_end;
  logic in_arb;

  always_comb begin
    nxt_bit      = 1'b1;
    nxt_stuff    = 1'b0;
    nxt_from_pre = 1'b0;
    nxt_from_crc = 1'b0;
    shift_end    = 1'b0;
    if (run_cnt == 3'd5 && !last_crc) begin
      nxt_bit   = ~run_val;
      nxt_stuff = 1'b1;
    end else if (pre_left != 7'd0) begin
      nxt_bit      = sreg[102];
      nxt_from_pre = 1'b1;
    end else if (crc_left != 4'd0) begin
      nxt_bit      = crc[14];
      nxt_from_crc = 1'b1;
    end else begin
      shift_end = 1'b1;
    end
    // ID..RTR (ext, SRR and IDE included) or ID..IDE (std)
    in_arb = !cur_stuff && (bit_idx != 7'd0) &&
             (bit_idx <= (ide_q ? 7'd32 : 7'd13));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_WAIT_IDLE;
      idle_cnt       <= 8'd0;
      bit_tx         <= 1'b1;
      tx.tx_ready    <= 1'b0;
      tx.tx_done     <= 1'b0;
      tx.tx_acked    <= 1'b0;
      tx.tx_arb_lost <= 1'b0;
      tx.tx_err      <= 1'b0;
      sreg           <= '0;
      pre_total      <= 7'd0;
      pre_left       <= 7'd0;
      ide_q          <= 1'b0;
      crc            <= 15'd0;
      crc_left       <= 4'd0;
      last_crc       <= 1'b0;
      cur_stuff      <= 1'b0;
      bit_idx        <= 7'd0;
      run_cnt        <= 3'd0;
      run_val        <= 1'b1;
      ack_q          <= 1'b0;
    end else begin
      tx.tx_done     <= 1'b0;
      tx.tx_arb_lost <= 1'b0;
      tx.tx_err      <= 1'b0;

      // The handshake is honoured on any edge; the bit-timed logic below
      // only sees the frame from the next strobe on.
      if (state == S_IDLE && tx.tx_valid && tx.tx_ready) begin
        sreg        <= frame_vec;
        pre_total   <= frame_bits;
        ide_q       <= tx.tx_ide;
        tx.tx_ready <= 1'b0;
        state       <= S_PEND;
      end

      if (bit_req) begin
        case (state)
          S_WAIT_IDLE: begin
            bit_tx <= 1'b1;
            if (bit_rx) begin
              if (idle_cnt + 8'd1 >= IDLE_CNT) begin
                idle_cnt    <= IDLE_CNT;
                state       <= S_IDLE;
                tx.tx_ready <= 1'b1;
              end else begin
                idle_cnt <= idle_cnt + 8'd1;
              end
            end else begin
              idle_cnt <= 8'd0;
            end
          end

          S_IDLE: begin
            if (!bit_rx)                   idle_cnt <= 8'd0;
            else if (idle_cnt < IDLE_CNT)  idle_cnt <= idle_cnt + 8'd1;
          end

          S_PEND: begin
            if (!bit_rx) begin
              idle_cnt <= 8'd0;
            end else if (idle_cnt >= IDLE_CNT) begin
              bit_tx    <= 1'b0;
              sreg      <= {sreg[101:0], 1'b0};
              pre_left  <= pre_total - 7'd1;
              crc       <= 15'd0;  // SOF is dominant, CRC stays at its init
              crc_left  <= 4'd15;
              last_crc  <= 1'b0;
              cur_stuff <= 1'b0;
              bit_idx   <= 7'd0;
              run_cnt   <= 3'd1;
              run_val   <= 1'b0;
              state     <= S_SHIFT;
            end else begin
              idle_cnt <= idle_cnt + 8'd1;
            end
          end

          S_SHIFT: begin
            if (bit_rx != bit_tx) begin
              if (bit_tx && in_arb) tx.tx_arb_lost <= 1'b1;
              else                  tx.tx_err      <= 1'b1;
              bit_tx   <= 1'b1;
              idle_cnt <= 8'd0;
              state    <= S_WAIT_IDLE;
            end else if (shift_end) begin
              bit_tx <= 1'b1;
              state  <= S_CRC_DEL;
            end else begin
              bit_tx    <= nxt_bit;
              cur_stuff <= nxt_stuff;
              run_cnt   <= (nxt_bit == run_val) ? run_cnt + 3'd1 : 3'd1;
              run_val   <= nxt_bit;
              if (nxt_from_pre) begin
                sreg     <= {sreg[101:0], 1'b0};
                pre_left <= pre_left - 7'd1;
                crc      <= crc_step(crc, nxt_bit);
                bit_idx  <= bit_idx + 7'd1;
              end
              if (nxt_from_crc) begin
                crc      <= {crc[13:0], 1'b0};
                crc_left <= crc_left - 4'd1;
                last_crc <= (crc_left == 4'd1);
              end
            end
          end

          S_CRC_DEL: begin
            bit_tx <= 1'b1;
            if (!bit_rx) begin
              tx.tx_err <= 1'b1;
              idle_cnt  <= 8'd0;
              state     <= S_WAIT_IDLE;
            end else begin
              state <= S_ACK_SLOT;
            end
          end

          S_ACK_SLOT: begin
            bit_tx <= 1'b1;
            ack_q  <= ~bit_rx;
            state  <= S_ACK_DEL;
          end

          S_ACK_DEL: begin
            bit_tx <= 1'b1;
            if (bit_rx) begin
              tx.tx_done  <= 1'b1;
              tx.tx_acked <= ack_q;
            end else begin
              tx.tx_err <= 1'b1;
            end
            // EOF and intermission are covered by the idle count
            idle_cnt <= 8'd0;
            state    <= S_WAIT_IDLE;
          end

          default: begin
            bit_tx   <= 1'b1;
            idle_cnt <= 8'd0;
            state    <= S_WAIT_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_can_frame_tx.sv
// tb_can_frame_tx
//   Directed bench for can_frame_tx. The bus is modelled as the DUT's own
//   bit echoed back, with individual bits overridden where a scenario needs
//   a dominant ACK, a lost arbitration or a busy bus.
module tb_can_frame_tx;
  logic clk = 1'b0;
  logic rst;
  logic bit_req;
  logic bit_rx;
  logic bit_tx;

  can_frame_tx_if txif ();

  can_frame_tx #(.IDLE_BITS(11)) dut (
    .clk     (clk),
    .rst     (rst),
    .bit_req (bit_req),
    .bit_rx  (bit_rx),
    .bit_tx  (bit_tx),
    .tx      (txif)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // golden frame: unstuffed and stuffed SOF..CRC
  logic gu [0:127];
  int   gu_n;
  logic gs [0:191];
  int   gs_n;
  logic cap [0:191];
  logic obs_del, obs_done, obs_acked, obs_err, obs_arb;

  task automatic put(input logic b);
    gu[gu_n] = b;
    gu_n++;
  endtask

  task automatic build_gold(input logic [28:0] id, input logic ide, input logic rtr,
                            input logic [3:0] len, input logic [63:0] data);
    int nd;
    int run;
    logic [14:0] c;
    logic fb;
    logic last;
    gu_n = 0;
    put(1'b0);
    if (ide) begin
      for (int i = 28; i >= 18; i--) put(id[i]);
      put(1'b1); put(1'b1);
      for (int i = 17; i >= 0; i--) put(id[i]);
      put(rtr); put(1'b0); put(1'b0);
    end else begin
      for (int i = 10; i >= 0; i--) put(id[i]);
      put(rtr); put(1'b0); put(1'b0);
    end
    for (int i = 3; i >= 0; i--) put(len[i]);
    nd = rtr ? 0 : ((len > 4'd8) ? 64 : 8 * int'(len));
    for (int i = 0; i < nd; i++) put(data[63 - i]);
    c = 15'd0;
    for (int i = 0; i < gu_n; i++) begin
      fb = gu[i] ^ c[14];
      c  = {c[13:0], 1'b0};
      if (fb) c = c ^ 15'h4599;
    end
    for (int i = 14; i >= 0; i--) put(c[i]);
    gs_n = 0;
    run  = 0;
    last = 1'b0;
    for (int i = 0; i < gu_n; i++) begin
      if (gs_n > 0 && gu[i] == last) run++;
      else run = 1;
      last = gu[i];
      gs[gs_n] = gu[i];
      gs_n++;
      if (run == 5 && i != gu_n - 1) begin
        gs[gs_n] = ~last;
        gs_n++;
        last = ~last;
        run  = 1;
      end
    end
  endtask

  // one bit time: strobe at a clk edge, return at the following negedge
  task automatic strobe(input logic rx);
    @(negedge clk);
    bit_req = 1'b1;
    bit_rx  = rx;
    @(negedge clk);
    bit_req = 1'b0;
    bit_rx  = 1'b1;
  endtask

  task automatic offer(input logic [28:0] id, input logic ide, input logic rtr,
                       input logic [3:0] len, input logic [63:0] data, output logic ok);
    build_gold(id, ide, rtr, len, data);
    ok = 1'b0;
    for (int i = 0; i < 40 && txif.tx_ready !== 1'b1; i++) strobe(1'b1);
    if (txif.tx_ready === 1'b1) begin
      @(negedge clk);
      txif.tx_valid = 1'b1;
      txif.tx_id    = id;
      txif.tx_ide   = ide;
      txif.tx_rtr   = rtr;
      txif.tx_len   = len;
      txif.tx_data  = data;
      @(negedge clk);
      txif.tx_valid = 1'b0;
      ok = 1'b1;
    end
  endtask

  task automatic xmit(input logic ack_rx, input logic sof_sent);
    if (!sof_sent) strobe(1'b1);
    cap[0] = bit_tx;
    for (int k = 1; k < gs_n; k++) begin
      strobe(bit_tx);
      cap[k] = bit_tx;
    end
    strobe(bit_tx);
    obs_del = bit_tx;
    strobe(1'b1);
    strobe(ack_rx);
    strobe(1'b1);
    obs_done  = txif.tx_done;
    obs_acked = txif.tx_acked;
    obs_err   = txif.tx_err;
    obs_arb   = txif.tx_arb_lost;
  endtask

  function automatic int stream_diffs();
    int bad = 0;
    for (int k = 0; k < gs_n; k++) if (cap[k] !== gs[k]) bad++;
    return bad;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    bit_req = 1'b0;
    bit_rx = 1'b1;
    txif.tx_valid = 1'b0;
    txif.tx_id = '0; txif.tx_ide = 1'b0; txif.tx_rtr = 1'b0;
    txif.tx_len = '0; txif.tx_data = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (bit_tx !== 1'b1) begin errors++; $display("FAIL reset_bit_tx: got %b want 1", bit_tx); end
    checks++; if (txif.tx_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", txif.tx_ready); end
    checks++; if ({txif.tx_done, txif.tx_acked, txif.tx_arb_lost, txif.tx_err} !== 4'b0000) begin
      errors++; $display("FAIL reset_pulses: got %b want 0000", {txif.tx_done, txif.tx_acked, txif.tx_arb_lost, txif.tx_err}); end
    repeat (10) strobe(1'b1);
    checks++; if (txif.tx_ready !== 1'b0) begin errors++; $display("FAIL reset_idle10: ready got %b want 0", txif.tx_ready); end
    strobe(1'b1);
    checks++; if (txif.tx_ready !== 1'b1) begin errors++; $display("FAIL reset_idle11: ready got %b want 1", txif.tx_ready); end
  endtask

  task automatic test_std_data();
    logic ok;
    int bad;
    offer(29'h456, 1'b0, 1'b0, 4'd4, 64'h12345678_00000000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL std_offer: ready not seen within bound"); end
    checks++; if (txif.tx_ready !== 1'b0) begin errors++; $display("FAIL std_ready_drop: got %b want 0", txif.tx_ready); end
    xmit(1'b0, 1'b0);
    bad = stream_diffs();
    checks++; if (bad != 0) begin errors++; $display("FAIL std_stream: %0d differing bits, want 0", bad); end
    checks++; if (obs_del !== 1'b1) begin errors++; $display("FAIL std_crc_del: got %b want 1", obs_del); end
    checks++; if (obs_done !== 1'b1 || obs_acked !== 1'b1) begin
      errors++; $display("FAIL std_done: done=%b acked=%b want 1 1", obs_done, obs_acked); end
    checks++; if (obs_err !== 1'b0 || obs_arb !== 1'b0) begin
      errors++; $display("FAIL std_no_err: err=%b arb=%b want 0 0", obs_err, obs_arb); end
    @(negedge clk);
    checks++; if (txif.tx_done !== 1'b0 || txif.tx_acked !== 1'b1) begin
      errors++; $display("FAIL std_pulse_width: done=%b acked=%b want 0 1", txif.tx_done, txif.tx_acked); end
  endtask

  task automatic test_no_ack();
    logic ok;
    int bad;
    offer(29'h456, 1'b0, 1'b0, 4'd4, 64'h12345678_00000000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL noack_offer: ready not seen within bound"); end
    xmit(1'b1, 1'b0);
    bad = stream_diffs();
    checks++; if (bad != 0) begin errors++; $display("FAIL noack_stream: %0d differing bits, want 0", bad); end
    checks++; if (obs_done !== 1'b1 || obs_acked !== 1'b0) begin
      errors++; $display("FAIL noack_done: done=%b acked=%b want 1 0", obs_done, obs_acked); end
    repeat (10) strobe(1'b1);
    checks++; if (txif.tx_ready !== 1'b0) begin errors++; $display("FAIL noack_idle10: ready got %b want 0", txif.tx_ready); end
    strobe(1'b1);
    checks++; if (txif.tx_ready !== 1'b1) begin errors++; $display("FAIL noack_idle11: ready got %b want 1", txif.tx_ready); end
  endtask

  task automatic test_stuff_zero();
    logic ok;
    int ones;
    logic [5:0] head;
    offer(29'h0, 1'b0, 1'b0, 4'd0, 64'h0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL zero_offer: ready not seen within bound"); end
    xmit(1'b0, 1'b0);
    head = {cap[0], cap[1], cap[2], cap[3], cap[4], cap[5]};
    checks++; if (head !== 6'b000001) begin errors++; $display("FAIL zero_head: got %b want 000001", head); end
    // all 34 unstuffed bits are 0, so every 1 is a stuff bit: 40 bits, 6 stuffs
    ones = 0;
    for (int k = 0; k < 40; k++) if (cap[k] === 1'b1) ones++;
    checks++; if (ones != 6) begin errors++; $display("FAIL zero_stuff_count: got %0d want 6", ones); end
    checks++; if (gs_n != 40 || stream_diffs() != 0) begin
      errors++; $display("FAIL zero_stream: len %0d diffs %0d want 40 0", gs_n, stream_diffs()); end
    checks++; if (obs_del !== 1'b1 || obs_done !== 1'b1) begin
      errors++; $display("FAIL zero_done: del=%b done=%b want 1 1", obs_del, obs_done); end
  endtask

  task automatic test_ext_rtr();
    logic ok;
    logic du [0:127];
    int n;
    int run;
    logic prev;
    logic skip;
    logic [3:0] dlc;
    offer(29'h1ABCDEF0, 1'b1, 1'b1, 4'd8, 64'hDEADBEEF_CAFEF00D, ok);
    checks++; if (!ok) begin errors++; $display("FAIL ext_offer: ready not seen within bound"); end
    xmit(1'b0, 1'b0);
    checks++; if (stream_diffs() != 0) begin errors++; $display("FAIL ext_stream: %0d differing bits, want 0", stream_diffs()); end
    n = 0; run = 0; prev = 1'b0; skip = 1'b0;
    for (int i = 0; i < gs_n; i++) begin
      if (skip) begin
        skip = 1'b0; prev = cap[i]; run = 1;
      end else begin
        du[n] = cap[i];
        n++;
        run = (i > 0 && cap[i] === prev) ? run + 1 : 1;
        prev = cap[i];
        if (run == 5) skip = 1'b1;
      end
    end
    // 39 header bits, no data, 15 CRC bits
    checks++; if (n != 54) begin errors++; $display("FAIL ext_len: got %0d want 54", n); end
    dlc = {du[35], du[36], du[37], du[38]};
    checks++; if (dlc !== 4'b1000 || du[32] !== 1'b1) begin
      errors++; $display("FAIL ext_dlc_rtr: dlc=%b rtr=%b want 1000 1", dlc, du[32]); end
    checks++; if (obs_done !== 1'b1 || obs_acked !== 1'b1) begin
      errors++; $display("FAIL ext_done: done=%b acked=%b want 1 1", obs_done, obs_acked); end
  endtask

  task automatic test_arb_lost();
    logic ok;
    logic stuck;
    offer(29'h7FF, 1'b0, 1'b0, 4'd1, 64'hA5000000_00000000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL arb_offer: ready not seen within bound"); end
    strobe(1'b1);
    checks++; if (bit_tx !== 1'b0) begin errors++; $display("FAIL arb_sof: got %b want 0", bit_tx); end
    strobe(bit_tx);      // ID10 loaded
    strobe(bit_tx);      // ID9 loaded
    strobe(1'b0);        // another node wins on ID9
    checks++; if (txif.tx_arb_lost !== 1'b1 || txif.tx_err !== 1'b0 || bit_tx !== 1'b1) begin
      errors++; $display("FAIL arb_pulse: arb=%b err=%b bit_tx=%b want 1 0 1", txif.tx_arb_lost, txif.tx_err, bit_tx); end
    @(negedge clk);
    checks++; if (txif.tx_arb_lost !== 1'b0) begin errors++; $display("FAIL arb_width: got %b want 0", txif.tx_arb_lost); end
    stuck = 1'b0;
    for (int k = 0; k < 15; k++) begin
      strobe((k % 3 == 2) ? 1'b0 : 1'b1);
      if (bit_tx !== 1'b1 || txif.tx_ready !== 1'b0) stuck = 1'b1;
    end
    repeat (10) begin
      strobe(1'b1);
      if (bit_tx !== 1'b1 || txif.tx_ready !== 1'b0) stuck = 1'b1;
    end
    checks++; if (stuck) begin errors++; $display("FAIL arb_quiet: bit_tx or ready moved early, want bit_tx=1 ready=0"); end
    strobe(1'b1);
    checks++; if (txif.tx_ready !== 1'b1) begin errors++; $display("FAIL arb_ready11: got %b want 1", txif.tx_ready); end
  endtask

  task automatic test_pend_dominant();
    logic ok;
    logic early;
    offer(29'h123, 1'b0, 1'b0, 4'd2, 64'hBEEF0000_00000000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL pend_offer: ready not seen within bound"); end
    strobe(1'b0);
    early = (bit_tx !== 1'b1);
    repeat (11) begin
      strobe(1'b1);
      if (bit_tx !== 1'b1) early = 1'b1;
    end
    checks++; if (early) begin errors++; $display("FAIL pend_hold: SOF before 11 recessive bits, want bit_tx=1"); end
    strobe(1'b1);
    checks++; if (bit_tx !== 1'b0) begin errors++; $display("FAIL pend_sof: got %b want 0", bit_tx); end
    xmit(1'b0, 1'b1);
    checks++; if (stream_diffs() != 0 || obs_done !== 1'b1) begin
      errors++; $display("FAIL pend_frame: diffs=%0d done=%b want 0 1", stream_diffs(), obs_done); end
  endtask

  task automatic test_reset_midframe();
    logic ok;
    logic resent;
    offer(29'h456, 1'b0, 1'b0, 4'd4, 64'h12345678_00000000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rstmid_offer: ready not seen within bound"); end
    strobe(1'b1);
    repeat (28) strobe(bit_tx);   // well inside the data field
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (bit_tx !== 1'b1 || txif.tx_ready !== 1'b0) begin
      errors++; $display("FAIL rstmid_out: bit_tx=%b ready=%b want 1 0", bit_tx, txif.tx_ready); end
    checks++; if ({txif.tx_done, txif.tx_acked, txif.tx_arb_lost, txif.tx_err} !== 4'b0000) begin
      errors++; $display("FAIL rstmid_pulses: got %b want 0000", {txif.tx_done, txif.tx_acked, txif.tx_arb_lost, txif.tx_err}); end
    resent = 1'b0;
    repeat (40) begin
      strobe(1'b1);
      if (bit_tx !== 1'b1) resent = 1'b1;
    end
    checks++; if (resent) begin errors++; $display("FAIL rstmid_resend: bit_tx went dominant, want 1"); end
    checks++; if (txif.tx_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b want 1", txif.tx_ready); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_std_data();
    test_no_ack();
    test_stuff_zero();
    test_ext_rtr();
    test_arb_lost();
    test_pend_dominant();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/can_frame_tx.md
Name: can_frame_tx

Overview:
- Full-featured CAN 2.0A/2.0B frame transmitter that sits directly on the bit-level layer's req/rbit/tbit strobe interface, in parallel with the packet receiver.
- Accepts one user frame: 11- or 29-bit ID, data or remote, DLC 0–15, up to 8 data bytes.
- Waits for bus idle, serialises SOF through CRC with bit stuffing and CRC-15, and monitors the bus for arbitration loss and bit/form errors.
- Samples the ACK slot and reports the outcome.

Parameters:
IDLE_BITS, 11, consecutive recessive sampled bits required before SOF may be driven (range 1..255).

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
bit_req  in  1  one-cycle strobe per bit time, at the sample point (from bit layer)
bit_rx  in  1  bus value sampled for the current bit; valid when bit_req=1
bit_tx  out  1  registered bit to drive; 1 = recessive
tx_valid  in  1  frame offered
tx_ready  out  1  frame accepted when tx_valid & tx_ready on a clk edge
tx_id  in  29  ID; std frames use tx_id[10:0]
tx_ide  in  1  1 = extended frame
tx_rtr  in  1  1 = remote frame
tx_len  in  4  DLC, sent verbatim
tx_data  in  64  byte0 = tx_data[63:56], MSB first
tx_done  out  1  pulse: frame completed through ACK delimiter
tx_acked  out  1  valid with tx_done: 1 = ACK slot sampled dominant
tx_arb_lost  out  1  pulse: arbitration lost, frame dropped
tx_err  out  1  pulse: bit or form error, frame dropped

Behaviour:
- Reset values: bit_tx=1, tx_ready=0, all pulses 0, state WAIT_IDLE, idle counter 0. Any held frame is discarded.
- bit_tx, state and counters change only on edges with bit_req=1. Exceptions: tx_ready and the frame latch update on any edge.
- Pulse outputs are high for exactly one clk cycle.
- Rule at every bit_req while transmitting: bit_rx is the bus value of the bit currently on bit_tx, and bit_tx is loaded with the next bit.

States:
- WAIT_IDLE:
  - bit_tx=1.
  - Counter increments on bit_rx=1 and clears on bit_rx=0.
  - When the counter reaches IDLE_BITS, go to IDLE.
- IDLE:
  - tx_ready=1.
  - On handshake, latch all fields, set tx_ready=0 the next cycle, and go to PEND.
  - The idle counter keeps running, saturating at IDLE_BITS.
- PEND:
  - At a bit_req with bit_rx=1 and the counter already ≥ IDLE_BITS: drive bit_tx=0 (SOF) and go to SHIFT.
  - At a bit_req with bit_rx=0: clear the counter and keep the frame; transmission retries automatically after idle is seen again.
- SHIFT:
  - Sequence, unstuffed:
    - Standard: SOF, ID[10:0], RTR, IDE=0, r0=0, DLC[3:0], data, CRC[14:0].
    - Extended: SOF, ID[28:18], SRR=1, IDE=1, ID[17:0], RTR, r1=0, r0=0, DLC, data, CRC.
  - Data bits: 0 if RTR, otherwise 8*min(tx_len,8).
  - CRC: polynomial 0x4599, init 0, computed over the unstuffed bits SOF..last data bit, MSB first.
  - Stuffing: after 5 consecutive equal transmitted bits (stuff bits included in the run), insert their complement. This applies from SOF through the last CRC bit.
  - A stuff bit is never inserted after the final CRC bit. If the run of 5 ends on the last CRC bit, the following bit is the CRC delimiter.
- Arbitration window: ID through RTR, plus IDE for standard frames.
  - bit_tx=1 and bit_rx=0 on a non-stuff bit in the window: pulse tx_arb_lost, bit_tx=1, go to WAIT_IDLE with the counter cleared.
  - Any other mismatch (stuff bits, bits outside the window, or bit_tx=0 read 1): pulse tx_err, bit_tx=1, go to WAIT_IDLE.
- CRC_DEL: drive 1. If it reads 0, signal tx_err.
- ACK_SLOT: drive 1. Record ack = ~bit_rx.
- ACK_DEL: drive 1.
  - Reads 1: pulse tx_done with tx_acked=ack.
  - Reads 0: pulse tx_err instead.
  - In both cases go to WAIT_IDLE; this covers EOF and intermission.
- tx_acked holds its value until the next tx_done.
- Unacked frames are not retried.
- A frame is never dropped except via tx_arb_lost, tx_err, or rst.

Test Plan:
1. Std ID 0x456, data frame, len 4, data 0x12345678_00000000; bench forces ACK dominant.
   - Required: unstuffed SOF..CRC = 66 bits matching a golden model.
   - Required: tx_done=1 and tx_acked=1 one cycle after the ACK_DEL strobe.
2. Same frame with no ACK -> tx_done=1, tx_acked=0, tx_ready reasserted after 11 recessive bits.
3. Std ID 0x000, len 0 -> bit_tx reads 0,0,0,0,0,1(stuff),… and the stuff count matches the golden model.
4. Ext ID 0x1ABCDEF0 with rtr=1, len 8 -> no data bits, DLC=1000 sent, CRC correct.
5. Std ID 0x7FF; bench forces bit_rx=0 at ID bit 9 -> tx_arb_lost pulse, bit_tx=1 for every remaining bit, tx_ready reasserts only after IDLE_BITS recessive bits.
6. Bus dominant while in PEND -> no SOF until 11 recessive bits. Separately, assert rst during the data field -> bit_tx=1, all outputs at reset values, and the frame is not resent.
